fifo_wr_framer: RTL and testbench
=================================

Name: fifo_wr_framer

Overview:
Write-side producer for the async FIFO. Accepts a valid/ready stream of 16-bit beats with an end-of-frame flag and pushes them into the FIFO write port as 17-bit words. Closes every frame with a trailer word carrying the beat count and an 8-bit XOR checksum, so the read-side consumer can delimit and check frames. Honours wfull; never writes to a full FIFO.

Parameters:
DATESIZE, 17, FIFO word width; only 17 supported (bit 16 = word type, bits 15:0 = payload)
MAX_BEATS, 255, maximum data beats per frame (1..255); frame is force-closed at this count

Ports:
wclk  in  1  write-domain clock
wrst_n  in  1  asynchronous active-low reset
s_valid  in  1  upstream beat valid
s_data  in  16  upstream beat payload
s_last  in  1  upstream beat is last of frame
s_ready  out  1  block accepts beat this cycle
wfull  in  1  FIFO full flag, wclk domain
wen  out  1  FIFO write enable
wdata  out  17  FIFO write data
busy  out  1  frame in progress (state != IDLE)
trunc_err  out  1  sticky: a frame was force-closed at MAX_BEATS
frame_cnt  out  16  trailers written (see Optional Feature)

Behaviour:
- Reset and clock: wrst_n, asynchronous, active-low; clock wclk. All state on posedge wclk.
- Reset values: state IDLE, count 0, csum 0, trunc_err 0, frame_cnt 0. s_ready and wen forced 0 while wrst_n low.
- Word format: data word = {1'b0, s_data}; trailer = {1'b1, count[7:0], csum[7:0]}.
- csum = running XOR of s_data[15:8] ^ s_data[7:0] over all data beats of the frame.
- States: IDLE, DATA, TRAILER.
- IDLE/DATA: s_ready = !wfull. Accept = s_valid && s_ready. On accept, same cycle: wen=1, wdata={0,s_data} (combinational, zero latency). Registered: count+1, csum updated, state DATA.
- Close condition on accept: s_last, or count+1 == MAX_BEATS -> next state TRAILER. If closed by MAX_BEATS with s_last=0, set trunc_err (sticky until reset); remaining upstream beats start a new frame.
- TRAILER: s_ready=0. When !wfull: wen=1, wdata=trailer using final count/csum (including the closing beat); next state IDLE, count/csum cleared, frame_cnt+1 (wraps at 2^16). When wfull: wen=0, hold.
- wen never asserted while wfull=1. wdata is {0,s_data} whenever state != TRAILER; meaningful only when wen=1.
- Throughput: N-beat frame takes at least N+1 wclk cycles; next frame's first beat accepted earliest the cycle after the trailer write.
- wfull rising mid-frame: s_ready drops the same cycle; no beat lost or duplicated; resumes when wfull falls.
- Reset mid-frame: partial frame abandoned, no trailer emitted, return to IDLE.
- busy = (state != IDLE).

Optional Feature:
FRAMER_STATS_EN: when defined, frame_cnt is a 16-bit register incremented on each trailer write, cleared by reset. When undefined, the register is not built and frame_cnt is tied to 16'h0000; all other behaviour is identical.

Test Plan:
- Frame 0x1234, 0x00FF, 0xA5A5(last), wfull=0 -> wen on 4 consecutive cycles, wdata 0x01234, 0x000FF, 0x0A5A5, 0x103D9; busy back to 0.
- Single beat 0xBEEF(last) -> wdata 0x0BEEF then trailer 0x10151; frame_cnt=1 with FRAMER_STATS_EN, 0 without.
- 6-beat frame with wfull held high for 5 cycles after beat 2 -> s_ready=0, wen=0 for those 5 cycles; all 6 data words plus trailer count 0x06 written in order, none duplicated.
- wfull high on the cycle after last beat for 3 cycles -> trailer held, written on first cycle wfull=0; s_ready=0 throughout.
- MAX_BEATS=4, six beats with s_last only on beat 6 -> trailer count 0x04 after beat 4, trunc_err=1; beats 5-6 form second frame with trailer count 0x02.
- wrst_n pulsed low after beat 2 of a frame -> wen=0, no trailer, busy=0, trunc_err=0; next frame's trailer count starts from 1.

Source files
------------

// File: rtl/fifo_wr_framer.sv
// -----------------------------------------------------------------------------
// fifo_wr_framer
//
// Write-side producer for the async FIFO. It takes a valid/ready stream of
// 16-bit beats with an end-of-frame flag and writes each beat to the FIFO as a
// 17-bit data word {1'b0, s_data}. Every frame is closed with a trailer word
// {1'b1, count[7:0], csum[7:0]}. The checksum is the running XOR of both
// payload bytes over all data beats, so the read side can delimit and check
// frames. The block never writes while wfull is high.
//
// If a frame reaches MAX_BEATS beats without s_last, it is closed and the
// sticky trunc_err flag is set. Any remaining upstream beats then start a new
// frame.
//
// Ports
//   wclk       write-domain clock
//   wrst_n     asynchronous active-low reset
//   s_valid    upstream beat valid
//   s_data     upstream beat payload (16 bits)
//   s_last     upstream beat is last of frame
//   s_ready    beat accepted this cycle when s_valid is also high
//   wfull      FIFO full flag (wclk domain)
//   wen        FIFO write enable
//   wdata      FIFO write data (DATESIZE bits; bit 16 = trailer marker)
//   busy       frame in progress
//   trunc_err  sticky: a frame was force-closed at MAX_BEATS
//   frame_cnt  number of trailers written (wraps at 2^16)
//
// Build option
//   FRAMER_STATS_EN  when defined, frame_cnt is a real counter. When it is
//                    not defined, frame_cnt is tied to zero.
// -----------------------------------------------------------------------------
module fifo_wr_framer #(
  parameter int DATESIZE  = 17,
  parameter int MAX_BEATS = 255
) (
  input  logic                wclk,
  input  logic                wrst_n,
  input  logic                s_valid,
  input  logic [15:0]         s_data,
  input  logic                s_last,
  output logic                s_ready,
  input  logic                wfull,
  output logic                wen,
  output logic [DATESIZE-1:0] wdata,
  output logic                busy,
  output logic                trunc_err,
  output logic [15:0]         frame_cnt
);

  if (DATESIZE != 17) begin : g_bad_datesize
    $error("fifo_wr_framer supports DATESIZE = 17 only");
  end
  if (MAX_BEATS < 1 || MAX_BEATS > 255) begin : g_bad_max_beats
    $error("fifo_wr_framer MAX_BEATS must be in 1..255");
  end

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    TRAILER
  } state_t;

  state_t     state;
  logic [7:0] count;
  logic [7:0] csum;

  logic       accept;
  logic [8:0] count_inc;
  logic       close_max;

  assign accept    = s_valid && s_ready;
  // Computed one bit wider so that MAX_BEATS = 255 compares without wrapping.
  assign count_inc = {1'b0, count} + 9'd1;
  assign close_max = (count_inc == 9'(MAX_BEATS));

  // The handshake is combinational. A beat reaches the FIFO in the same cycle
  // it is accepted, and s_ready follows wfull with no delay, so no beat is
  // ever accepted while it cannot be written.
  // NOTE: every output is given a default at the top of the always_comb, so
  // no path leaves one unassigned and no latch is inferred.
  always_comb begin
    s_ready = 1'b0;
    wen     = 1'b0;
    wdata   = {1'b0, s_data};
    if (wrst_n) begin
      if (state == TRAILER) begin
        wen   = !wfull;
        wdata = {1'b1, count, csum};
      end else begin
        s_ready = !wfull;
        wen     = s_valid && !wfull;
      end
    end
  end

  // NOTE: registered state is updated with non-blocking assignments only.
  // Every register then samples values from before the clock edge, and the
  // result does not depend on the order of the statements.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state     <= IDLE;
      count     <= 8'd0;
      csum      <= 8'd0;
      trunc_err <= 1'b0;
    end else begin
      case (state)
        IDLE, DATA: begin
          if (accept) begin
            count <= count_inc[7:0];
            csum  <= csum ^ s_data[15:8] ^ s_data[7:0];
            if (s_last || close_max) begin
              state <= TRAILER;
              if (!s_last) trunc_err <= 1'b1;
            end else begin
              state <= DATA;
            end
          end
        end
        TRAILER: begin
          // Hold the trailer until the FIFO has room. The count and csum stay
          // in place, so the trailer word stays stable while it waits.
          if (!wfull) begin
            state <= IDLE;
            count <= 8'd0;
            csum  <= 8'd0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

`ifdef FRAMER_STATS_EN
  logic trailer_wr;
  assign trailer_wr = (state == TRAILER) && !wfull;

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      frame_cnt <= 16'h0000;
    end else if (trailer_wr) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end
`else
  assign frame_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_fifo_wr_framer.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_framer
//
// Self-checking bench for fifo_wr_framer. Two instances share one input
// stream: dut0 uses the default MAX_BEATS = 255 and dut1 uses MAX_BEATS = 4.
//
// A frame-level model follows each instance. It keeps the beats of the open
// frame in an array and computes the trailer from them on demand. The model is
// compared against the DUT outputs on every falling edge. The directed
// sequences also check literal word logs worked out by hand.
// -----------------------------------------------------------------------------
module tb_fifo_wr_framer;

  localparam int MAXB0 = 255;
  localparam int MAXB1 = 4;

  logic        wclk = 1'b0;
  logic        wrst_n;
  logic        s_valid;
  logic [15:0] s_data;
  logic        s_last;
  logic        wfull;

  logic        s_ready_o   [2];
  logic        wen_o       [2];
  logic [16:0] wdata_o     [2];
  logic        busy_o      [2];
  logic        trunc_o     [2];
  logic [15:0] frame_cnt_o [2];

  int n_tests = 0;
  int n_fail  = 0;

  // Model state for each instance.
  int          len    [2];
  bit          pend   [2];
  bit          trunc_m[2];
  int          frames [2];
  logic [15:0] bufm   [2][256];

  // Every word written to the FIFO, one log per instance.
  logic [16:0] log0[$];
  logic [16:0] log1[$];

  always #5 wclk = ~wclk;

  fifo_wr_framer #(.DATESIZE(17), .MAX_BEATS(MAXB0)) dut0 (
    .wclk      (wclk),
    .wrst_n    (wrst_n),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_last    (s_last),
    .s_ready   (s_ready_o[0]),
    .wfull     (wfull),
    .wen       (wen_o[0]),
    .wdata     (wdata_o[0]),
    .busy      (busy_o[0]),
    .trunc_err (trunc_o[0]),
    .frame_cnt (frame_cnt_o[0])
  );

  fifo_wr_framer #(.DATESIZE(17), .MAX_BEATS(MAXB1)) dut1 (
    .wclk      (wclk),
    .wrst_n    (wrst_n),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_last    (s_last),
    .s_ready   (s_ready_o[1]),
    .wfull     (wfull),
    .wen       (wen_o[1]),
    .wdata     (wdata_o[1]),
    .busy      (busy_o[1]),
    .trunc_err (trunc_o[1]),
    .frame_cnt (frame_cnt_o[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Checksum of the open frame, computed directly from the stored beats.
  function automatic logic [7:0] frame_csum(input int i);
    logic [7:0] c = 8'h00;
    for (int k = 0; k < len[i]; k++) c = c ^ bufm[i][k][15:8] ^ bufm[i][k][7:0];
    return c;
  endfunction

  // Compares one instance against the model, then advances the model across
  // the next rising edge using the inputs that are currently applied.
  task automatic model_step(input int i);
    int          mx;
    logic        e_ready, e_wen, e_busy;
    logic [16:0] e_wdata;
    logic [15:0] e_fcnt;
    mx = (i == 0) ? MAXB0 : MAXB1;
    if (!wrst_n) begin
      len[i] = 0; pend[i] = 0; trunc_m[i] = 0; frames[i] = 0;
    end
    e_ready = 1'b0;
    e_wen   = 1'b0;
    e_wdata = {1'b0, s_data};
    if (wrst_n) begin
      if (pend[i]) begin
        e_wen   = !wfull;
        e_wdata = {1'b1, 8'(len[i]), frame_csum(i)};
      end else begin
        e_ready = !wfull;
        e_wen   = s_valid && !wfull;
      end
    end
    e_busy = pend[i] || (len[i] > 0);
`ifdef FRAMER_STATS_EN
    e_fcnt = 16'(frames[i]);
`else
    e_fcnt = 16'h0000;
`endif
    check($sformatf("s_ready[%0d]", i), 32'(s_ready_o[i]), 32'(e_ready));
    check($sformatf("wen[%0d]", i), 32'(wen_o[i]), 32'(e_wen));
    check($sformatf("busy[%0d]", i), 32'(busy_o[i]), 32'(e_busy));
    check($sformatf("trunc_err[%0d]", i), 32'(trunc_o[i]), 32'(trunc_m[i]));
    check($sformatf("frame_cnt[%0d]", i), 32'(frame_cnt_o[i]), 32'(e_fcnt));
    if (e_wen) check($sformatf("wdata[%0d]", i), 32'(wdata_o[i]), 32'(e_wdata));
    if (wen_o[i]) begin
      if (i == 0) log0.push_back(wdata_o[0]);
      else        log1.push_back(wdata_o[1]);
    end
    if (wrst_n) begin
      if (pend[i]) begin
        if (!wfull) begin
          len[i] = 0; pend[i] = 0; frames[i]++;
        end
      end else if (e_wen) begin
        bufm[i][len[i]] = s_data;
        len[i]++;
        if (s_last || len[i] == mx) pend[i] = 1;
        if (!s_last && len[i] == mx) trunc_m[i] = 1;
      end
    end
  endtask

  always @(negedge wclk) begin
    for (int i = 0; i < 2; i++) model_step(i);
  end

  // Present one beat and hold it until the selected instance accepts it.
  task automatic drive_beat(input int sel, input logic [15:0] d, input logic l);
    bit acc = 0;
    s_valid = 1'b1; s_data = d; s_last = l;
    for (int t = 0; t < 100 && !acc; t++) begin
      @(negedge wclk);
      acc = s_ready_o[sel];
      @(posedge wclk); #1;
    end
    check("beat_accept", 32'(acc), 32'd1);
    s_valid = 1'b0;
  endtask

  task automatic wait_idle(input int sel);
    bit done = 0;
    s_valid = 1'b0;
    for (int t = 0; t < 50 && !done; t++) begin
      @(negedge wclk);
      done = !busy_o[sel];
      @(posedge wclk); #1;
    end
    check("idle_wait", 32'(done), 32'd1);
  endtask

  task automatic do_reset();
    wrst_n = 1'b0;
    @(posedge wclk); #1;
    wrst_n = 1'b1;
  endtask

  initial begin
    wrst_n = 1'b0; s_valid = 1'b0; s_data = 16'h0; s_last = 1'b0; wfull = 1'b0;
    @(negedge wclk);
    check("rst_s_ready", 32'(s_ready_o[0]), 32'd0);
    check("rst_busy", 32'(busy_o[0]), 32'd0);
    check("rst_trunc", 32'(trunc_o[0]), 32'd0);
    check("rst_frame_cnt", 32'(frame_cnt_o[0]), 32'd0);
    repeat (2) @(posedge wclk);
    #1 wrst_n = 1'b1;

    // Three-beat frame: three data words, then trailer 0x103D9.
    log0.delete();
    drive_beat(0, 16'h1234, 1'b0);
    drive_beat(0, 16'h00FF, 1'b0);
    drive_beat(0, 16'hA5A5, 1'b1);
    wait_idle(0);
    check("t1_len", 32'(log0.size()), 32'd4);
    if (log0.size() == 4) begin
      check("t1_w0", 32'(log0[0]), 32'h01234);
      check("t1_w1", 32'(log0[1]), 32'h000FF);
      check("t1_w2", 32'(log0[2]), 32'h0A5A5);
      check("t1_w3", 32'(log0[3]), 32'h103D9);
    end
    check("t1_busy", 32'(busy_o[0]), 32'd0);

    // Single-beat frame after reset: 0x0BEEF, then trailer 0x10151.
    do_reset();
    log0.delete();
    drive_beat(0, 16'hBEEF, 1'b1);
    wait_idle(0);
    check("t2_len", 32'(log0.size()), 32'd2);
    if (log0.size() == 2) begin
      check("t2_w0", 32'(log0[0]), 32'h0BEEF);
      check("t2_w1", 32'(log0[1]), 32'h10151);
    end
`ifdef FRAMER_STATS_EN
    check("t2_frame_cnt", 32'(frame_cnt_o[0]), 32'd1);
`else
    check("t2_frame_cnt", 32'(frame_cnt_o[0]), 32'd0);
`endif

    // Six-beat frame; wfull held high for 5 cycles after beat 2.
    log0.delete();
    drive_beat(0, 16'h0100, 1'b0);
    drive_beat(0, 16'h0200, 1'b0);
    wfull = 1'b1; s_valid = 1'b1; s_data = 16'h0300; s_last = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge wclk);
      check("t3_ready_low", 32'(s_ready_o[0]), 32'd0);
      check("t3_wen_low", 32'(wen_o[0]), 32'd0);
      @(posedge wclk); #1;
    end
    wfull = 1'b0;
    for (int k = 3; k <= 6; k++) drive_beat(0, 16'(k) << 8, k == 6);
    wait_idle(0);
    check("t3_len", 32'(log0.size()), 32'd7);
    if (log0.size() == 7) begin
      for (int k = 0; k < 6; k++) check("t3_data", 32'(log0[k]), 32'((k + 1) << 8));
      check("t3_trailer", 32'(log0[6]), 32'h10607);
    end

    // wfull high for 3 cycles right after the last beat: trailer is held.
    log0.delete();
    drive_beat(0, 16'h0102, 1'b0);
    drive_beat(0, 16'h0304, 1'b1);
    wfull = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge wclk);
      check("t4_wen_held", 32'(wen_o[0]), 32'd0);
      check("t4_ready_low", 32'(s_ready_o[0]), 32'd0);
      @(posedge wclk); #1;
    end
    wfull = 1'b0;
    @(negedge wclk);
    check("t4_wen", 32'(wen_o[0]), 32'd1);
    check("t4_trailer", 32'(wdata_o[0]), 32'h10204);
    check("t4_ready_low", 32'(s_ready_o[0]), 32'd0);
    @(posedge wclk); #1;
    wait_idle(0);

    // MAX_BEATS = 4 instance: six beats, s_last only on beat 6.
    do_reset();
    log1.delete();
    check("t5_trunc_pre", 32'(trunc_o[1]), 32'd0);
    for (int k = 1; k <= 6; k++) drive_beat(1, 16'(k), k == 6);
    wait_idle(1);
    check("t5_trunc", 32'(trunc_o[1]), 32'd1);
    check("t5_len", 32'(log1.size()), 32'd8);
    if (log1.size() == 8) begin
      check("t5_trailer_a", 32'(log1[4]), 32'h10404);
      check("t5_trailer_b", 32'(log1[7]), 32'h10203);
      check("t5_beat5", 32'(log1[5]), 32'h00005);
    end

    // Reset after beat 2: no trailer; the next frame counts from 1.
    log0.delete();
    drive_beat(0, 16'hAAAA, 1'b0);
    drive_beat(0, 16'h5555, 1'b0);
    wrst_n = 1'b0;
    @(negedge wclk);
    check("t6_wen", 32'(wen_o[0]), 32'd0);
    check("t6_busy", 32'(busy_o[0]), 32'd0);
    @(posedge wclk); #1;
    wrst_n = 1'b1;
    @(negedge wclk);
    check("t6_trunc", 32'(trunc_o[1]), 32'd0);
    check("t6_no_trailer", 32'(log0.size()), 32'd2);
    @(posedge wclk); #1;
    drive_beat(0, 16'h0007, 1'b1);
    wait_idle(0);
    check("t6_len", 32'(log0.size()), 32'd4);
    if (log0.size() == 4) check("t6_trailer", 32'(log0[3]), 32'h10107);

    // Random traffic, checked cycle by cycle by the model.
    for (int c = 0; c < 3000; c++) begin
      wrst_n  = ($urandom_range(0, 299) != 0);
      s_valid = ($urandom_range(0, 9) < 7);
      s_data  = 16'($urandom);
      s_last  = ($urandom_range(0, 5) == 0);
      wfull   = ($urandom_range(0, 3) == 0);
      @(posedge wclk); #1;
    end
    wrst_n = 1'b1; s_valid = 1'b0; wfull = 1'b0;
    repeat (5) @(posedge wclk);
    #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
